// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type and width helpers for the reset sequencer.
package reset_seq_pkg;
    typedef enum logic {STAGE, DONE} state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: button/qualifier inputs and sequenced reset outputs of the reset sequencer.
interface reset_sequencer_if #(parameter int NUM_OUT = 3);
    logic               btn;
    logic               dep_ready;
    logic [NUM_OUT-1:0] rst_out;
    logic               seq_busy;
    logic               btn_event;

    modport master (output btn, dep_ready, input rst_out, seq_busy, btn_event);
    modport slave  (input btn, dep_ready, output rst_out, seq_busy, btn_event);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises the raw button, debounces it and pulses o_rise on each accepted 0->1 change.
module btn_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   w_diff;
    logic                   w_term;

    assign w_diff = r_sync[SYNC_STAGES-1] ^ r_level;
    assign w_term = r_cnt == CW'(DEBOUNCE_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_rise  <= w_term && !r_level;
            r_level <= w_term ? ~r_level : r_level;
            r_cnt   <= (w_term || !w_diff) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: asserts NUM_OUT resets on power-up or button press and releases them in index order.
// Define RESET_SEQ_DEP_GATE_EN to make stages above 0 count only while dep_ready is high.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT         = 3,
    parameter int STRETCH         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input logic              clk,
    input logic              rst,
    reset_sequencer_if.slave bus
);
    localparam int CW = cnt_w(STRETCH);
    localparam int IW = idx_w(NUM_OUT);

    state_t             r_state, w_state;
    logic [IW-1:0]      r_idx, w_idx;
    logic [CW-1:0]      r_cnt, w_cnt;
    logic [NUM_OUT-1:0] r_out, w_out;
    logic               r_busy;
    logic               w_rise;
    logic               w_qual;
    logic               w_last;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .i_btn (bus.btn),
        .o_rise(w_rise)
    );

`ifdef RESET_SEQ_DEP_GATE_EN
    assign w_qual = (r_idx == '0) || bus.dep_ready;
`else
    logic w_unused_dep;
    assign w_unused_dep = bus.dep_ready;
    assign w_qual       = 1'b1;
`endif

    assign w_last = r_cnt == CW'(STRETCH - 1);

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_out   = r_out;
        // a button event restarts the whole sequence from any state
        if (w_rise) begin
            w_state = STAGE;
            w_idx   = '0;
            w_cnt   = '0;
            w_out   = '1;
        end else if (r_state == STAGE && w_qual) begin
            w_cnt = w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                w_out[r_idx] = 1'b0;
                w_idx        = r_idx + IW'(1);
                w_state      = (r_idx == IW'(NUM_OUT - 1)) ? DONE : STAGE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STAGE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= '1;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_out   <= w_out;
            r_busy  <= |w_out;
        end
    end

    assign bus.rst_out   = r_out;
    assign bus.seq_busy  = r_busy;
    assign bus.btn_event = w_rise;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for the ML505 top level. It synchronises and debounces the user reset push-button. On power-up or a button press it asserts `NUM_OUT` active-high resets together, then releases them one at a time in index order with a programmable spacing. Release of outputs above index 0 can optionally wait for a dependency-ready input, such as the memory controller's `init_done`. It replaces the hand-built shift-register and counter reset logic in the top level.

## Interface
- `NUM_OUT`, 3: number of sequenced reset outputs; must be ≥ 1.
- `STRETCH`, 4: qualifying cycles each stage waits before releasing its output; must be ≥ 1.
- `SYNC_STAGES`, 2: flops in the button synchroniser; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 8: consecutive agreeing synchronised samples needed to accept a button level change; must be ≥ 1.

- `clk` input, 1 bit: the single clock. All state is on its rising edge.
- `rst` input, 1 bit: reset is asynchronous and active-high; e.g. driven by `~pll_lock`.
- `btn` input, 1 bit: raw push-button level, asynchronous to `clk`.
- `dep_ready` input, 1 bit: dependency-ready qualifier, e.g. `init_done`.
- `rst_out` output, `NUM_OUT` bits: sequenced resets, active-high. `rst_out[0]` is released first.
- `seq_busy` output, 1 bit: high while any `rst_out` bit is asserted.
- `btn_event` output, 1 bit: one-cycle pulse on each accepted rising edge of the debounced button.

## Operation
- **Reset values (while `rst` is high):**
  - `rst_out` is all ones, `seq_busy` is 1, `btn_event` is 0.
  - The synchroniser chain, debounced level, and all counters are 0.
  - The FSM is in `STAGE` with index 0.
- **Debounce:**
  - `btn` passes through `SYNC_STAGES` flops.
  - The counter increments while the synchronised value differs from the debounced level. It clears whenever the two agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A 0→1 flip pulses `btn_event` on that same edge. A 1→0 flip produces no event.
- **FSM states:**
  - `STAGE(i)`, for i = 0..NUM_OUT-1: the stage counter increments on each qualifying edge. When it reaches `STRETCH`, `rst_out[i]` clears on that edge, the counter clears, and the FSM goes to `STAGE(i+1)`, or to `DONE` when i = NUM_OUT-1.
  - `DONE`: `rst_out` is 0 and `seq_busy` is 0.
- **Qualifying edge:** every edge, except in `STAGE(i)` with i ≥ 1 when the gate is compiled in (see Configuration). There, an edge qualifies only if `dep_ready` is sampled high.
- **Restart:** `btn_event` high in any state, including mid-sequence, does the following on the next edge:
  - sets `rst_out` to all ones and `seq_busy` to 1;
  - moves the FSM to `STAGE(0)` and clears the stage counter.
- **Async reset mid-operation:** `rst` overrides everything immediately, with no clock edge needed.
- **Counter widths:**
  - stage counter: `$clog2(STRETCH+1)` bits;
  - debounce counter: `$clog2(DEBOUNCE_CYCLES+1)` bits;
  - neither counter wraps, because each clears when it hits its terminal value.
- **Output stability:** released outputs never re-assert except through restart or `rst`. Outputs are registered and glitch-free.

## Timing
- Edge 1 is the first rising edge with `rst` low.
- With `dep_ready` held high, `rst_out[i]` falls at edge (i+1)·`STRETCH`.
- `seq_busy` falls on the same edge as `rst_out[NUM_OUT-1]`.
- Button latency, from the first edge sampling `btn` high to the `btn_event` edge: `SYNC_STAGES` + `DEBOUNCE_CYCLES` edges. `rst_out` becomes all ones one edge later.
- Unconditional rule: `rst_out[i]` is released only after `rst_out[i-1]` has been released.

## Configuration
- Macro: `RESET_SEQ_DEP_GATE_EN`.
- Defined: stages i ≥ 1 count only on edges where `dep_ready` is high. With `dep_ready` stuck low, the outputs hold at …110 indefinitely.
- Undefined: `dep_ready` is ignored (port kept, unconnected internally). Every edge qualifies.

## Structure
- Package `reset_seq_pkg` holds:
  - the FSM state typedef (`STAGE`, `DONE`);
  - the stage-index and counter-width helper functions.
- Sub-module `btn_debounce` contains the synchroniser, debounce counter and rising-edge pulse, and is parametrised by `SYNC_STAGES` and `DEBOUNCE_CYCLES`.
- The top of the block holds the FSM and the output register.

## Test plan
All scenarios use `NUM_OUT`=3, `STRETCH`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8.
- **Power-up, `dep_ready`=1:** `rst` falls before edge 1 → `rst_out` = 111 until edge 4, then 110 at 4, 100 at 8, 000 at 12; `seq_busy` falls at 12.
- **Gated release (macro defined):** `dep_ready`=0 until it is first sampled high at edge 20 → `rst_out` = 110 from edge 4 through 22, 100 at 23, 000 at 27. With the macro undefined, the timing matches the power-up case.
- **Glitch rejection:** in `DONE`, `btn` high for 5 cycles then low → no `btn_event`; `rst_out` stays 000.
- **Press from `DONE`:** `btn` first sampled high at edge e and held for 20 cycles → `btn_event` pulses at e+10; `rst_out` = 111 at e+11; releases at e+15, e+19, e+23; releasing the button produces no event.
- **Press mid-sequence:** event while `rst_out`=110 → next edge `rst_out`=111 and the counter restarts; the next release comes 4 edges later.
- **Async reset:** `rst` raised between edges while `rst_out`=100 → `rst_out`=111 and `seq_busy`=1 before the next edge, and held until `rst` falls.
